// File: rtl/display_source_scheduler.sv
// display_source_scheduler
//   Chooses which 32-bit debug value drives the seven-segment display
//   controller. N_SRC sources share the display through debounced button
//   stepping or timed auto-rotation; a hold channel can freeze one captured
//   value on screen, and takes priority over stepping.
// Ports
//   clk           system clock, all logic on posedge
//   rst           synchronous active-high reset
//   src_data      packed sources, source i at [32*i+31 : 32*i]
//   src_valid     per-source eligibility for display
//   btn_next      raw step button, active high
//   auto_en       enables timed rotation
//   hold_req      level request for the hold channel
//   hold_data     value captured on hold grant
//   hold_ack      one-cycle pulse on hold grant
//   number        registered value for the display controller
//   cur_src       index of the source currently shown
//   showing_hold  high while the captured hold value is on screen
module display_source_scheduler #(
    parameter int N_SRC          = 4,
    parameter int SEL_W          = 2,
    parameter int ROTATE_TICKS   = 100_000_000,
    parameter int DEBOUNCE_TICKS = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC*32-1:0]  src_data,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic                 btn_next,
    input  logic                 auto_en,
    input  logic                 hold_req,
    input  logic [31:0]          hold_data,
    output logic                 hold_ack,
    output logic [31:0]          number,
    output logic [SEL_W-1:0]     cur_src,
    output logic                 showing_hold
);

    localparam int ROT_W = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic {SHOW, HOLD} state_t;

    state_t             state_q, state_d;
    logic [DB_W-1:0]    db_cnt;
    logic               db_level;
    logic               db_flip, man_step, auto_step, do_step;
    logic [ROT_W-1:0]   rot_cnt, rot_d;
    logic [31:0]        sel_data, shown_data, number_d;
    logic [SEL_W-1:0]   next_idx, cur_src_d;
    logic [SEL_W:0]     cand;
    logic               found, hold_ack_d;

    // ---------------- debounce ----------------
    // The level flips on the DEBOUNCE_TICKS-th consecutive disagreeing sample;
    // a manual step is that flip when it goes low->high.
    assign db_flip  = (btn_next != db_level) && (db_cnt == DB_W'(DEBOUNCE_TICKS - 1));
    assign man_step = db_flip && !db_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (btn_next == db_level) begin
            db_cnt   <= '0;
        end else if (db_flip) begin
            db_level <= ~db_level;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + 1'b1;
        end
    end

    // ---------------- source mux / step search ----------------
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++)
            if (cur_src == SEL_W'(i)) sel_data = src_data[32*i +: 32];
    end

    assign shown_data = src_valid[cur_src] ? sel_data : 32'h0;

    // First valid index after cur_src, wrapping; cur_src itself when none.
    always_comb begin
        next_idx = cur_src;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k < N_SRC; k++) begin
            cand = {1'b0, cur_src} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N_SRC)) cand = cand - (SEL_W+1)'(N_SRC);
            if (!found && src_valid[cand[SEL_W-1:0]]) begin
                next_idx = cand[SEL_W-1:0];
                found    = 1'b1;
            end
        end
    end

    assign auto_step = (state_q == SHOW) && auto_en && (rot_cnt == ROT_W'(ROTATE_TICKS - 1));
    // A hold request in the same cycle swallows any step; manual+auto collapse to one.
    assign do_step   = (state_q == SHOW) && !hold_req && (man_step || auto_step);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= SHOW;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW:    if (hold_req)  state_d = HOLD;
            HOLD:    if (!hold_req) state_d = SHOW;
            default: state_d = SHOW;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        number_d   = number;
        cur_src_d  = cur_src;
        hold_ack_d = 1'b0;
        rot_d      = rot_cnt;
        case (state_q)
            SHOW: begin
                if (!auto_en || man_step || auto_step) rot_d = '0;
                else                                   rot_d = rot_cnt + 1'b1;
                if (hold_req) begin
                    number_d   = hold_data;
                    hold_ack_d = 1'b1;
                end else begin
                    number_d = shown_data;
                    if (do_step) cur_src_d = next_idx;
                end
            end
            HOLD: begin
                // number and rot_cnt stay frozen until release
                if (!hold_req) begin
                    rot_d    = '0;
                    number_d = shown_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            number   <= '0;
            cur_src  <= '0;
            hold_ack <= 1'b0;
            rot_cnt  <= '0;
        end else begin
            number   <= number_d;
            cur_src  <= cur_src_d;
            hold_ack <= hold_ack_d;
            rot_cnt  <= rot_d;
        end
    end

    assign showing_hold = (state_q == HOLD);

endmodule

// File: tb/tb_display_source_scheduler.sv
module tb_display_source_scheduler;
    localparam int N_SRC = 4;
    localparam int SEL_W = 2;
    localparam logic [31:0] A = 32'h1111_1111, B = 32'h2222_2222,
                            C = 32'h3333_3333, D = 32'h4444_4444;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_SRC*32-1:0] src_data;
    logic [N_SRC-1:0]    src_valid;
    logic                btn_next, auto_en, hold_req;
    logic [31:0]         hold_data;
    logic                hold_ack;
    logic [31:0]         number;
    logic [SEL_W-1:0]    cur_src;
    logic                showing_hold;

    always #5 clk = ~clk;

    display_source_scheduler #(
        .N_SRC(N_SRC), .SEL_W(SEL_W), .ROTATE_TICKS(8), .DEBOUNCE_TICKS(4)
    ) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
        .btn_next(btn_next), .auto_en(auto_en), .hold_req(hold_req),
        .hold_data(hold_data), .hold_ack(hold_ack), .number(number),
        .cur_src(cur_src), .showing_hold(showing_hold)
    );

    typedef struct {
        string            tag;
        logic [31:0]      num;
        logic [SEL_W-1:0] src;
        logic             ack;
        logic             hold;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expectation with the stimulus, let n edges pass, then compare.
    task automatic expect_after(input string tag, input int n, input logic [31:0] num,
                                input logic [SEL_W-1:0] src, input logic ack, input logic hold);
        exp_t e;
        e.tag = tag; e.num = num; e.src = src; e.ack = ack; e.hold = hold;
        sb.push_back(e);
        cyc(n);
        e = sb.pop_front();
        chk({e.tag, ".number"},       number,            e.num);
        chk({e.tag, ".cur_src"},      32'(cur_src),      32'(e.src));
        chk({e.tag, ".hold_ack"},     32'(hold_ack),     32'(e.ack));
        chk({e.tag, ".showing_hold"}, 32'(showing_hold), 32'(e.hold));
    endtask

    initial begin
        rst = 1'b1; src_data = {D, C, B, A}; src_valid = 4'hF;
        btn_next = 1'b0; auto_en = 1'b0; hold_req = 1'b0; hold_data = '0;
        cyc(1);
        expect_after("reset", 1, 32'h0, 0, 0, 0);
        rst = 1'b0;
        expect_after("first", 1, A, 0, 0, 0);

        // short glitch then a real press
        btn_next = 1'b1; cyc(3);
        btn_next = 1'b0;
        expect_after("glitch", 2, A, 0, 0, 0);
        btn_next = 1'b1;
        expect_after("press", 10, B, 1, 0, 0);
        btn_next = 1'b0;
        expect_after("release", 6, B, 1, 0, 0);

        // auto rotation over valid=1011 from index 0
        rst = 1'b1; src_valid = 4'b1011; cyc(1);
        rst = 1'b0; auto_en = 1'b1;
        expect_after("auto_pre", 7, A, 0, 0, 0);
        expect_after("auto_1", 1, A, 1, 0, 0);
        expect_after("auto_3", 8, B, 3, 0, 0);
        expect_after("auto_0", 8, D, 0, 0, 0);

        // hold freezes value and rotation
        cyc(3);
        hold_req = 1'b1; hold_data = 32'hDEAD_BEEF;
        expect_after("hold_grant", 1, 32'hDEAD_BEEF, 0, 1, 1);
        hold_data = 32'h1234_5678;
        expect_after("hold_frozen", 1, 32'hDEAD_BEEF, 0, 0, 1);
        expect_after("hold_noauto", 12, 32'hDEAD_BEEF, 0, 0, 1);
        hold_req = 1'b0;
        expect_after("hold_exit", 1, A, 0, 0, 0);
        expect_after("rot_cleared", 7, A, 0, 0, 0);
        expect_after("rot_after_exit", 1, A, 1, 0, 0);

        // re-grant the cycle after exit
        auto_en = 1'b0; hold_req = 1'b1; hold_data = 32'hCAFE_0001;
        expect_after("regrant_1", 1, 32'hCAFE_0001, 1, 1, 1);
        hold_req = 1'b0;
        expect_after("regrant_x1", 1, B, 1, 0, 0);
        hold_req = 1'b1; hold_data = 32'hCAFE_0002;
        expect_after("regrant_2", 1, 32'hCAFE_0002, 1, 1, 1);
        hold_req = 1'b0;
        expect_after("regrant_x2", 1, B, 1, 0, 0);

        // hold and debounced press in the same cycle
        btn_next = 1'b1; cyc(3);
        hold_req = 1'b1; hold_data = 32'h0BAD_F00D;
        expect_after("hold_vs_step", 1, 32'h0BAD_F00D, 1, 1, 1);
        hold_req = 1'b0;
        expect_after("hold_vs_step_x", 1, B, 1, 0, 0);
        btn_next = 1'b0; cyc(5);

        // presses during hold are discarded
        hold_req = 1'b1; hold_data = 32'h7777_0000;
        expect_after("hold_press_g", 1, 32'h7777_0000, 1, 1, 1);
        btn_next = 1'b1; cyc(8);
        btn_next = 1'b0; cyc(6);
        hold_req = 1'b0;
        expect_after("hold_press_x", 1, B, 1, 0, 0);

        // nothing valid
        src_valid = 4'b0000;
        expect_after("none_valid", 1, 32'h0, 1, 0, 0);
        btn_next = 1'b1; auto_en = 1'b1;
        expect_after("none_step", 10, 32'h0, 1, 0, 0);
        btn_next = 1'b0; auto_en = 1'b0; cyc(5);

        // wrap to the single valid source, then no-other-valid
        src_valid = 4'b0001; btn_next = 1'b1;
        expect_after("wrap_step", 4, 32'h0, 0, 0, 0);
        expect_after("wrap_num", 1, A, 0, 0, 0);
        btn_next = 1'b0; cyc(5);
        btn_next = 1'b1;
        expect_after("only_self", 6, A, 0, 0, 0);
        btn_next = 1'b0; cyc(5);

        // reset in hold, mid-debounce
        hold_req = 1'b1; hold_data = 32'h55AA_55AA;
        expect_after("pre_rst_hold", 1, 32'h55AA_55AA, 0, 1, 1);
        btn_next = 1'b1; cyc(2);
        rst = 1'b1; btn_next = 1'b0;
        expect_after("rst_in_hold", 1, 32'h0, 0, 0, 0);
        rst = 1'b0; hold_req = 1'b0; src_valid = 4'hF;
        expect_after("post_rst", 1, A, 0, 0, 0);

        // manual and auto step land on the same edge: one step only
        auto_en = 1'b1; cyc(4);
        btn_next = 1'b1;
        expect_after("dual_pre", 3, A, 0, 0, 0);
        expect_after("dual_step", 1, A, 1, 0, 0);
        btn_next = 1'b0; auto_en = 1'b0;
        expect_after("dual_after", 6, B, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
